// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer for the FFT-1024 serial-to-4-parallel converter: framing, converter control, quad flags.
// Build option: define S2P_SOP_RESYNC_EN to restart framing on a mid-frame SOP.
module s2p_frame_ctrl #(
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sop,
    output logic             in_ready,
    input  logic             fft_ready,
    output logic             s2p_enable,
    output logic [1:0]       s2p_counter,
    output logic             quad_valid,
    output logic [IDX_W-1:0] quad_idx,
    output logic             frame_start,
    output logic             frame_done,
    output logic             sop_err
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned      GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN / 4 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             qv_q, qv_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fs_q, fs_d;
    logic             fd_q, fd_d;
    logic             err_q, err_d;

    logic accept;
    logic sop_mid;
    logic resync;

    assign in_ready = fft_ready && (state_q == S_IDLE || state_q == S_FILL);
    assign accept   = in_valid && in_ready;
    assign sop_mid  = accept && in_sop && (state_q == S_FILL);

`ifdef S2P_SOP_RESYNC_EN
    assign resync = sop_mid;
`else
    assign resync = 1'b0;
`endif

    assign quad_valid  = qv_q;
    assign quad_idx    = idx_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign sop_err     = err_q;

    // Counter (k+3) mod 4 makes counter 3 land on samples 4q, so each quad moves out one sample late.
    always_comb begin
        s2p_enable  = 1'b0;
        s2p_counter = k_q[1:0] + 2'd3;
        unique case (state_q)
            S_IDLE: s2p_enable = accept && in_sop;
            S_FILL: begin
                s2p_enable = accept;
                if (resync) s2p_counter = 2'd3;
            end
            S_FLUSH: begin
                s2p_enable  = fft_ready;
                s2p_counter = 2'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        qv_d    = 1'b0;
        idx_d   = idx_q;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && in_sop) begin
                    k_d     = CNT_W'(1);
                    fs_d    = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    err_d = in_sop;
                    if (resync) begin
                        k_d  = CNT_W'(1);
                        fs_d = 1'b1;
                    end else begin
                        // k is never 0 here, so a k%4==0 accept always completes quad k/4-1.
                        if (k_q[1:0] == 2'd0) begin
                            qv_d  = 1'b1;
                            idx_d = IDX_W'(k_q[CNT_W-1:2]) - IDX_W'(1);
                        end
                        if (k_q == LAST_K) begin
                            k_d     = '0;
                            state_d = S_FLUSH;
                        end else begin
                            k_d = k_q + CNT_W'(1);
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (fft_ready) begin
                    qv_d  = 1'b1;
                    idx_d = LAST_IDX;
                    fd_d  = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP_LOAD);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else gap_d = gap_q - GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            gap_q   <= '0;
            qv_q    <= 1'b0;
            idx_q   <= '0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
            qv_q    <= qv_d;
            idx_q   <= idx_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    a_done_is_last_quad : assert property (@(posedge clk) disable iff (rst)
        fd_q |-> (qv_q && idx_q == LAST_IDX));

    a_fill_k_nonzero : assert property (@(posedge clk) disable iff (rst)
        (state_q == S_FILL) |-> (k_q != '0));

endmodule
